// File: rtl/seed_tx_pkg.sv
// Shared types, constants and elaboration helpers for the cipher-block pin serialiser.
package seed_tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StHi,
        StLo,
        StFin
    } tx_state_e;

    // About 20 ms per strobe phase at 100 MHz.
    localparam int unsigned DefHighCyc = 2097152;
    localparam int unsigned DefLowCyc  = 2097152;

    function automatic int unsigned calc_nchunk(input int unsigned block_w,
                                                input int unsigned chunk_w);
        return block_w / chunk_w;
    endfunction

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned width = 1;
        while ((64'(1) << width) < 64'(value)) width++;
        return width;
    endfunction

endpackage

// File: rtl/seed_blk_fifo.sv
// Small block-wide synchronous FIFO; flush empties it in one cycle.
module seed_blk_fifo import seed_tx_pkg::*; #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW   = clog2_min1(DEPTH);
    localparam int unsigned CNTW = clog2_min1(DEPTH + 1);
    localparam logic [PW-1:0]   PtrLast = PW'(DEPTH - 1);
    localparam logic [CNTW-1:0] CntFull = CNTW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]  count_q;
    logic             push_en, pop_en;

    assign full    = (count_q == CntFull);
    assign empty   = (count_q == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
            if (push_en && !pop_en)      count_q <= count_q + 1'b1;
            else if (pop_en && !push_en) count_q <= count_q - 1'b1;
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_en && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/seed_tx_serializer.sv
// Buffers whole cipher blocks and shifts them out chunk by chunk, each chunk
// qualified by a timed load_rpi3 strobe, optionally paced by the Pi's acknowledge.
module seed_tx_serializer import seed_tx_pkg::*; #(
    parameter int unsigned BLOCK_W    = 128,
    parameter int unsigned CHUNK_W    = 8,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned HIGH_CYC   = DefHighCyc,
    parameter int unsigned LOW_CYC    = DefLowCyc,
    parameter int unsigned MSB_FIRST  = 1,
    parameter int unsigned ACK_MODE   = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               blk_valid,
    input  logic [BLOCK_W-1:0] blk_data,
    output logic               blk_ready,
    input  logic               abort,
    input  logic               rpi_ack,
    output logic [CHUNK_W-1:0] part_data,
    output logic               load_rpi3,
    output logic               busy,
    output logic               done,
    output logic [15:0]        blk_cnt
);

    localparam int unsigned NCHUNK = calc_nchunk(BLOCK_W, CHUNK_W);
    localparam int unsigned TW = clog2_min1((HIGH_CYC > LOW_CYC ? HIGH_CYC : LOW_CYC) + 1);
    localparam int unsigned CW = clog2_min1(NCHUNK);
    localparam logic [TW-1:0] HiLast    = TW'(HIGH_CYC - 1);
    localparam logic [TW-1:0] LoLast    = TW'(LOW_CYC - 1);
    localparam logic [CW-1:0] ChunkLast = CW'(NCHUNK - 1);

    tx_state_e          state_q, state_d;
    logic [BLOCK_W-1:0] shreg_q, shreg_d, shifted;
    logic [CHUNK_W-1:0] part_q, part_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [CW-1:0]      chunk_q, chunk_d;
    logic               load_q, done_q;
    logic [15:0]        blk_cnt_q;
    logic               ack_meta_q, ack_sync_q, ack_ok;
    logic               fifo_full, fifo_empty, fifo_pop;
    logic [BLOCK_W-1:0] fifo_rdata;

    function automatic logic [CHUNK_W-1:0] send_chunk(input logic [BLOCK_W-1:0] b);
        if (MSB_FIRST != 0) return b[BLOCK_W-1 -: CHUNK_W];
        return b[CHUNK_W-1:0];
    endfunction

    assign blk_ready = !fifo_full;
    assign ack_ok    = (ACK_MODE == 0) || ack_sync_q;
    assign shifted   = (MSB_FIRST != 0) ? (shreg_q << CHUNK_W) : (shreg_q >> CHUNK_W);

    seed_blk_fifo #(
        .WIDTH (BLOCK_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (blk_valid && blk_ready && !abort),
        .wdata   (blk_data),
        .pop     (fifo_pop),
        .flush   (abort),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        part_d   = part_q;
        timer_d  = timer_q;
        chunk_d  = chunk_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            StIdle: if (!fifo_empty) state_d = StLoad;
            StLoad: begin
                fifo_pop = 1'b1;
                shreg_d  = fifo_rdata;
                part_d   = send_chunk(fifo_rdata);
                chunk_d  = '0;
                timer_d  = '0;
                state_d  = StHi;
            end
            StHi: begin
                if (timer_q == HiLast) begin
                    timer_d = '0;
                    state_d = StLo;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StLo: begin
                // Timer saturates so an acknowledge wait can last indefinitely.
                if (timer_q != LoLast) timer_d = timer_q + 1'b1;
                if (timer_q == LoLast && ack_ok) begin
                    timer_d = '0;
                    if (chunk_q == ChunkLast) begin
                        state_d = StFin;
                    end else begin
                        shreg_d = shifted;
                        part_d  = send_chunk(shifted);
                        chunk_d = chunk_q + 1'b1;
                        state_d = StHi;
                    end
                end
            end
            StFin: state_d = fifo_empty ? StIdle : StLoad;
            default: state_d = StIdle;
        endcase
        if (abort) begin
            state_d  = StIdle;
            part_d   = '0;
            timer_d  = '0;
            chunk_d  = '0;
            fifo_pop = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            part_q     <= '0;
            timer_q    <= '0;
            chunk_q    <= '0;
            load_q     <= 1'b0;
            done_q     <= 1'b0;
            blk_cnt_q  <= '0;
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            part_q     <= part_d;
            timer_q    <= timer_d;
            chunk_q    <= chunk_d;
            // Strobe follows the state by one cycle so data settles before it rises.
            load_q     <= (state_q == StHi) && !abort;
            done_q     <= (state_q == StFin) && !abort;
            if (state_q == StFin && !abort) blk_cnt_q <= blk_cnt_q + 16'd1;
            ack_meta_q <= rpi_ack;
            ack_sync_q <= ack_meta_q;
        end
    end

    assign part_data = part_q;
    assign load_rpi3 = load_q;
    assign done      = done_q;
    assign blk_cnt   = blk_cnt_q;
    assign busy      = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_seed_tx_serializer.sv
// Scoreboard bench: stimulus queues expected chunks, gaps and counts; a monitor
// pops and compares on every strobe edge and done pulse.
module tb_seed_tx_serializer;

    localparam int unsigned HC  = 4;
    localparam int unsigned LC  = 3;
    localparam int unsigned NCH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sel = 1'b0;
    logic        blk_valid = 1'b0;
    logic [31:0] blk_data = '0;
    logic        abort = 1'b0;
    logic        rpi_ack = 1'b0;

    logic        rdy_a, ld_a, busy_a, dn_a, rdy_b, ld_b, busy_b, dn_b;
    logic [7:0]  pd_a, pd_b;
    logic [15:0] cnt_a, cnt_b;
    logic        rdy, ld, busy, dn;
    logic [7:0]  pd;
    logic [15:0] cnt;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int push_cyc = 0;
    int done_cyc = -100;
    int b2b = 0;
    int mon_idx = 0;
    int flush_gen = 0;
    logic [7:0]  exp_chunk[$];
    int          exp_low[$];
    logic [15:0] exp_cnt[$];

    seed_tx_serializer #(
        .BLOCK_W(32), .CHUNK_W(8), .FIFO_DEPTH(2), .HIGH_CYC(HC), .LOW_CYC(LC),
        .MSB_FIRST(1), .ACK_MODE(0)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .blk_valid(blk_valid && !sel), .blk_data(blk_data),
        .blk_ready(rdy_a), .abort(abort), .rpi_ack(rpi_ack), .part_data(pd_a),
        .load_rpi3(ld_a), .busy(busy_a), .done(dn_a), .blk_cnt(cnt_a)
    );

    seed_tx_serializer #(
        .BLOCK_W(32), .CHUNK_W(8), .FIFO_DEPTH(2), .HIGH_CYC(HC), .LOW_CYC(LC),
        .MSB_FIRST(0), .ACK_MODE(1)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .blk_valid(blk_valid && sel), .blk_data(blk_data),
        .blk_ready(rdy_b), .abort(abort), .rpi_ack(rpi_ack), .part_data(pd_b),
        .load_rpi3(ld_b), .busy(busy_b), .done(dn_b), .blk_cnt(cnt_b)
    );

    assign rdy  = sel ? rdy_b  : rdy_a;
    assign ld   = sel ? ld_b   : ld_a;
    assign busy = sel ? busy_b : busy_a;
    assign dn   = sel ? dn_b   : dn_a;
    assign pd   = sel ? pd_b   : pd_a;
    assign cnt  = sel ? cnt_b  : cnt_a;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        logic       ld_prev = 1'b0;
        logic [7:0] pd_prev = '0;
        int seen_gen = 0;
        int rise_cyc = 0;
        int fall_cyc = 0;
        int chg_cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (seen_gen != flush_gen) begin
                seen_gen = flush_gen;
                mon_idx = 0;
                chg_cyc = cyc;
            end else begin
                if (ld && ld_prev) check("pd_stable_hi", 32'(pd), 32'(pd_prev));
                if (pd != pd_prev) chg_cyc = cyc;
                if (ld && !ld_prev) begin
                    if (exp_chunk.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexp_chunk: got 0x%0h, no chunk expected", pd);
                    end else begin
                        check("chunk", 32'(pd), 32'(exp_chunk.pop_front()));
                    end
                    check("strobe_lag", 32'(cyc - chg_cyc), 32'd1);
                    if (mon_idx > 0) begin
                        if (exp_low.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL low_width: got %0d, no gap expected", cyc - fall_cyc);
                        end else begin
                            check("low_width", 32'(cyc - fall_cyc), 32'(exp_low.pop_front()));
                        end
                    end
                    if (cyc - done_cyc == 2) b2b++;
                    mon_idx++;
                    rise_cyc = cyc;
                end
                if (!ld && ld_prev) begin
                    check("high_width", 32'(cyc - rise_cyc), HC);
                    fall_cyc = cyc;
                end
                if (dn) begin
                    if (exp_cnt.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexp_done: got blk_cnt %0d, no done expected", cnt);
                    end else begin
                        check("blk_cnt_at_done", 32'(cnt), 32'(exp_cnt.pop_front()));
                    end
                    check("chunks_per_blk", 32'(mon_idx), NCH);
                    mon_idx = 0;
                    done_cyc = cyc;
                end
            end
            ld_prev = ld;
            pd_prev = pd;
        end
    end

    task automatic flush_expect();
        flush_gen++;
        exp_chunk.delete();
        exp_low.delete();
        exp_cnt.delete();
    endtask

    task automatic do_reset();
        blk_valid = 1'b0;
        abort = 1'b0;
        reset_n = 1'b0;
        flush_expect();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, 32'(rdy), 32'd1);
        check({tag, "_load"}, 32'(ld), 32'd0);
        check({tag, "_part"}, 32'(pd), 32'd0);
        check({tag, "_done"}, 32'(dn), 32'd0);
        check({tag, "_cnt"}, 32'(cnt), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic expect_blk(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                              input logic [7:0] c3, input int l0, input int l1, input int l2,
                              input logic [15:0] n);
        exp_chunk.push_back(c0);
        exp_chunk.push_back(c1);
        exp_chunk.push_back(c2);
        exp_chunk.push_back(c3);
        exp_low.push_back(l0);
        exp_low.push_back(l1);
        exp_low.push_back(l2);
        exp_cnt.push_back(n);
    endtask

    task automatic push_blk(input logic [31:0] d);
        int n = 0;
        blk_valid = 1'b1;
        blk_data = d;
        while (!rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rdy) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: got blk_ready 0, required 1");
        end
        @(negedge clk);
        push_cyc = cyc;
        blk_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
        @(negedge clk);
        check("leftover_chunks", 32'(exp_chunk.size()), 32'd0);
    endtask

    task automatic wait_chunk(input int idx);
        int n = 0;
        while (!(mon_idx == idx && ld) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("chunk_wait", 32'(mon_idx), 32'(idx));
    endtask

    initial begin
        int b2b_base;
        int n;
        repeat (3) @(negedge clk);

        // 1: single block, MSB first
        do_reset();
        check_reset_state("t1_reset");
        expect_blk(8'hA1, 8'hB2, 8'hC3, 8'hD4, LC, LC, LC, 16'd1);
        push_blk(32'hA1B2C3D4);
        wait_idle(100);
        check("t1_done_latency", 32'(done_cyc - push_cyc), 32'd31);
        check("t1_cnt", 32'(cnt), 32'd1);

        // 3: three back-to-back blocks through a two-deep FIFO
        do_reset();
        expect_blk(8'h11, 8'h22, 8'h33, 8'h44, LC, LC, LC, 16'd1);
        expect_blk(8'h55, 8'h66, 8'h77, 8'h88, LC, LC, LC, 16'd2);
        expect_blk(8'h99, 8'hAA, 8'hBB, 8'hCC, LC, LC, LC, 16'd3);
        b2b_base = b2b;
        push_blk(32'h11223344);
        push_blk(32'h55667788);
        check("t3_ready_full", 32'(rdy), 32'd0);
        @(negedge clk);
        check("t3_ready_after_pop", 32'(rdy), 32'd1);
        push_blk(32'h99AABBCC);
        wait_idle(300);
        check("t3_back_to_back", 32'(b2b - b2b_base), 32'd2);
        check("t3_cnt", 32'(cnt), 32'd3);

        // 5: abort during chunk 2 with a block queued, plus a dropped push
        do_reset();
        expect_blk(8'h0F, 8'h1E, 8'h2D, 8'h3C, LC, LC, LC, 16'd1);
        expect_blk(8'h4B, 8'h5A, 8'h69, 8'h78, LC, LC, LC, 16'd2);
        push_blk(32'h0F1E2D3C);
        push_blk(32'h4B5A6978);
        wait_chunk(2);
        check("t5_ready_pre_abort", 32'(rdy), 32'd1);
        abort = 1'b1;
        blk_valid = 1'b1;
        blk_data = 32'hDEADBEEF;
        flush_expect();
        @(negedge clk);
        abort = 1'b0;
        blk_valid = 1'b0;
        check_reset_state("t5_abort");
        repeat (5) @(negedge clk);
        check("t5_dropped_push", 32'(busy), 32'd0);
        expect_blk(8'hC0, 8'hFF, 8'hEE, 8'h11, LC, LC, LC, 16'd1);
        push_blk(32'hC0FFEE11);
        wait_idle(100);
        check("t5_cnt", 32'(cnt), 32'd1);

        // 6: one-cycle reset mid-HI, then a fresh block from chunk 0
        do_reset();
        expect_blk(8'h13, 8'h57, 8'h9B, 8'hDF, LC, LC, LC, 16'd1);
        push_blk(32'h13579BDF);
        wait_chunk(1);
        do_reset();
        check_reset_state("t6_reset");
        expect_blk(8'h24, 8'h68, 8'hAC, 8'hE0, LC, LC, LC, 16'd1);
        push_blk(32'h2468ACE0);
        wait_idle(100);
        check("t6_cnt", 32'(cnt), 32'd1);

        // 2: LSB first (acknowledge mode with rpi_ack held high)
        sel = 1'b1;
        rpi_ack = 1'b1;
        do_reset();
        check_reset_state("t2_reset");
        expect_blk(8'hD4, 8'hC3, 8'hB2, 8'hA1, LC, LC, LC, 16'd1);
        push_blk(32'hA1B2C3D4);
        wait_idle(100);
        check("t2_cnt", 32'(cnt), 32'd1);

        // 4: acknowledge held low 20 cycles into the first LO
        rpi_ack = 1'b0;
        do_reset();
        expect_blk(8'hD4, 8'hC3, 8'hB2, 8'hA1, 22, LC, LC, 16'd1);
        push_blk(32'hA1B2C3D4);
        n = 0;
        while (!ld && n < 50) begin
            @(negedge clk);
            n++;
        end
        while (ld && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t4_first_fall", 32'(ld), 32'd0);
        repeat (18) @(negedge clk);
        check("t4_held_in_lo", 32'(mon_idx), 32'd1);
        rpi_ack = 1'b1;
        wait_idle(100);
        check("t4_cnt", 32'(cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
